// File: rtl/ilc_ctrl_if.sv
// Handshake bundle between the interruption requester, the CSR-SIM save/restore
// hooks and ilc_ctrl.
interface ilc_ctrl_if;
    logic ti_req;
    logic ti_load;
    logic pr_done;
    logic ti_gnt;
    logic save;
    logic restore;

    modport master (
        output ti_req,
        output ti_load,
        output pr_done,
        input  ti_gnt,
        input  save,
        input  restore
    );

    modport slave (
        input  ti_req,
        input  ti_load,
        input  pr_done,
        output ti_gnt,
        output save,
        output restore
    );
endinterface

// File: rtl/ilc_ctrl.sv
// Task-interruption controller: freezes top_main via clk_en, then runs a
// save/restore handshake with the CSR-SIM hooks before resuming execution.
module ilc_ctrl #(
    parameter int SETTLE_CYCLES  = 2,
    parameter int TIMEOUT_CYCLES = 1024,
    parameter int CNT_W          = 32
) (
    input  logic             i_clk,
    input  logic             i_rst,
    ilc_ctrl_if.slave        ti,
    input  logic [CNT_W-1:0] breakpoint,
    input  logic             ap_start,
    input  logic             ap_done,
    output logic             clk_en,
    output logic [CNT_W-1:0] cyc_cnt,
    output logic             bp_hit,
    output logic             timeout_err
);

    localparam int SW = (SETTLE_CYCLES > 1) ? $clog2(SETTLE_CYCLES) : 1;
    localparam int TW = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam logic [SW-1:0] SETTLE_LAST = SW'(SETTLE_CYCLES - 1);
    localparam logic [TW-1:0] TMO_LAST    = TW'(TIMEOUT_CYCLES - 1);

    typedef enum logic [1:0] {
        ST_RUN,
        ST_HALT,
        ST_OP,
        ST_RESUME
    } state_t;

    state_t           state_q, state_d;
    logic             op_restore_q, op_restore_d;
    logic             src_bp_q, src_bp_d;
    logic [SW-1:0]    settle_cnt_q, settle_cnt_d;
    logic [TW-1:0]    timer_q, timer_d;
    logic [CNT_W-1:0] cyc_cnt_q, cyc_cnt_d;
    logic             bp_hit_q, bp_hit_d;
    logic             timeout_err_q, timeout_err_d;
    logic             bp_armed_q, bp_armed_d;
    logic [CNT_W-1:0] bp_prev_q, bp_prev_d;
    logic             req_low_q, req_low_d;
    logic             clk_en_q, clk_en_d;
    logic             ti_gnt_q, ti_gnt_d;
    logic             save_q, save_d;
    logic             restore_q, restore_d;

    logic ext_go;
    logic bp_go;

    // A held request only starts a sequence once it has been observed low.
    assign ext_go = ti.ti_req && req_low_q;
    assign bp_go  = bp_armed_q && (breakpoint != '1) && (cyc_cnt_q == breakpoint);

    always_comb begin
        state_d       = state_q;
        op_restore_d  = op_restore_q;
        src_bp_d      = src_bp_q;
        settle_cnt_d  = settle_cnt_q;
        timer_d       = timer_q;
        cyc_cnt_d     = cyc_cnt_q;
        bp_hit_d      = bp_hit_q;
        timeout_err_d = timeout_err_q;
        bp_armed_d    = bp_armed_q;
        bp_prev_d     = breakpoint;
        req_low_d     = req_low_q;

        if (!ti.ti_req) begin
            req_low_d = 1'b1;
        end

        case (state_q)
            ST_RUN: begin
                if (ext_go) begin
                    op_restore_d = ti.ti_load;
                    src_bp_d     = 1'b0;
                    req_low_d    = 1'b0;
                    settle_cnt_d = '0;
                    state_d      = ST_HALT;
                end else if (bp_go) begin
                    op_restore_d = 1'b0;
                    src_bp_d     = 1'b1;
                    bp_hit_d     = 1'b1;
                    bp_armed_d   = 1'b0;
                    settle_cnt_d = '0;
                    state_d      = ST_HALT;
                end
            end
            ST_HALT: begin
                if (!src_bp_q && !ti.ti_req) begin
                    state_d = ST_RUN;
                end else if (settle_cnt_q == SETTLE_LAST) begin
                    timer_d = '0;
                    state_d = ST_OP;
                end else begin
                    settle_cnt_d = settle_cnt_q + 1'b1;
                end
            end
            ST_OP: begin
                if (ti.pr_done) begin
                    state_d = ST_RESUME;
                end else if (timer_q == TMO_LAST) begin
                    timeout_err_d = 1'b1;
                    state_d       = ST_RESUME;
                end else begin
                    timer_d = timer_q + 1'b1;
                end
            end
            ST_RESUME: begin
                if (src_bp_q || !ti.ti_req) begin
                    state_d = ST_RUN;
                end
            end
            default: state_d = ST_RUN;
        endcase

        if (breakpoint != bp_prev_q) begin
            bp_armed_d = 1'b1;
        end

        // The edge that decides to freeze is not counted, so cyc_cnt holds the
        // value that caused the halt and a deferred breakpoint still matches.
        if (clk_en_q && ap_start && !ap_done && (state_d == ST_RUN) &&
            (cyc_cnt_q != '1)) begin
            cyc_cnt_d = cyc_cnt_q + 1'b1;
        end

        clk_en_d  = (state_d == ST_RUN);
        ti_gnt_d  = (state_d == ST_OP) || (state_d == ST_RESUME);
        save_d    = (state_d == ST_OP) && !op_restore_d;
        restore_d = (state_d == ST_OP) && op_restore_d;
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state_q       <= ST_RUN;
            op_restore_q  <= 1'b0;
            src_bp_q      <= 1'b0;
            settle_cnt_q  <= '0;
            timer_q       <= '0;
            cyc_cnt_q     <= '0;
            bp_hit_q      <= 1'b0;
            timeout_err_q <= 1'b0;
            bp_armed_q    <= 1'b1;
            bp_prev_q     <= breakpoint;
            req_low_q     <= 1'b1;
            clk_en_q      <= 1'b1;
            ti_gnt_q      <= 1'b0;
            save_q        <= 1'b0;
            restore_q     <= 1'b0;
        end else begin
            state_q       <= state_d;
            op_restore_q  <= op_restore_d;
            src_bp_q      <= src_bp_d;
            settle_cnt_q  <= settle_cnt_d;
            timer_q       <= timer_d;
            cyc_cnt_q     <= cyc_cnt_d;
            bp_hit_q      <= bp_hit_d;
            timeout_err_q <= timeout_err_d;
            bp_armed_q    <= bp_armed_d;
            bp_prev_q     <= bp_prev_d;
            req_low_q     <= req_low_d;
            clk_en_q      <= clk_en_d;
            ti_gnt_q      <= ti_gnt_d;
            save_q        <= save_d;
            restore_q     <= restore_d;
        end
    end

    assign clk_en      = clk_en_q;
    assign cyc_cnt     = cyc_cnt_q;
    assign bp_hit      = bp_hit_q;
    assign timeout_err = timeout_err_q;
    assign ti.ti_gnt   = ti_gnt_q;
    assign ti.save     = save_q;
    assign ti.restore  = restore_q;

endmodule

// File: tb/tb_ilc_ctrl.sv
// Bench for ilc_ctrl: vector table, directed multi-cycle sequences and random
// traffic checked every cycle against a freeze/strobe timeline model.
module tb_ilc_ctrl;
    localparam int SETTLE = 2;
    localparam int TMO    = 16;
    localparam int CW     = 8;
    localparam int CMAX   = (1 << CW) - 1;

    logic          i_clk = 1'b0;
    logic          i_rst;
    logic [CW-1:0] breakpoint;
    logic          ap_start;
    logic          ap_done;
    logic          clk_en;
    logic [CW-1:0] cyc_cnt;
    logic          bp_hit;
    logic          timeout_err;

    ilc_ctrl_if tif();

    ilc_ctrl #(
        .SETTLE_CYCLES (SETTLE),
        .TIMEOUT_CYCLES(TMO),
        .CNT_W         (CW)
    ) dut (
        .i_clk      (i_clk),
        .i_rst      (i_rst),
        .ti         (tif),
        .breakpoint (breakpoint),
        .ap_start   (ap_start),
        .ap_done    (ap_done),
        .clk_en     (clk_en),
        .cyc_cnt    (cyc_cnt),
        .bp_hit     (bp_hit),
        .timeout_err(timeout_err)
    );

    always #5 i_clk = ~i_clk;

    // Inputs as seen by the DUT at each rising edge.
    logic          s_rst, s_req, s_load, s_pd, s_start, s_done;
    logic [CW-1:0] s_bp;
    always @(posedge i_clk) begin
        s_rst   <= i_rst;
        s_req   <= tif.ti_req;
        s_load  <= tif.ti_load;
        s_pd    <= tif.pr_done;
        s_start <= ap_start;
        s_done  <= ap_done;
        s_bp    <= breakpoint;
    end

    int checks = 0;
    int errors = 0;

    // Reference: a freeze is a timeline measured in edges since it began.
    int            m_cnt, m_age;
    bit            m_bp_hit, m_tmo, m_armed, m_seen_low;
    bit            m_in_seq, m_ext, m_restore, m_strobe_done;
    logic [CW-1:0] m_prev_bp;

    typedef struct packed {
        logic req, load, pd;
        logic ce, gnt, sv, rs;
    } vec_t;
    vec_t vecs[19];

    function automatic vec_t mk(logic req, logic load, logic pd,
                                logic ce, logic gnt, logic sv, logic rs);
        vec_t v;
        v.req = req; v.load = load; v.pd = pd;
        v.ce = ce; v.gnt = gnt; v.sv = sv; v.rs = rs;
        return v;
    endfunction

    task automatic checkOutput(string name, logic [31:0] act, logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_update();
        bit start_ext, start_bp;
        if (s_rst) begin
            m_cnt = 0; m_age = 0; m_bp_hit = 0; m_tmo = 0; m_armed = 1;
            m_seen_low = 1; m_in_seq = 0; m_ext = 0; m_restore = 0;
            m_strobe_done = 0; m_prev_bp = s_bp;
        end else begin
            if (!m_in_seq) begin
                start_ext = s_req && m_seen_low;
                start_bp  = !start_ext && m_armed && (s_bp != CW'(CMAX)) &&
                            (int'(s_bp) == m_cnt);
                if (start_ext || start_bp) begin
                    m_in_seq = 1; m_ext = start_ext; m_age = 0; m_strobe_done = 0;
                    m_restore = start_ext ? s_load : 1'b0;
                    if (start_bp) begin m_bp_hit = 1; m_armed = 0; end
                    if (start_ext) m_seen_low = 0;
                end else if (s_start && !s_done && m_cnt < CMAX) begin
                    m_cnt++;
                end
            end else begin
                m_age++;
                if (m_age <= SETTLE) begin
                    if (m_ext && !s_req) m_in_seq = 0;
                end else if (!m_strobe_done) begin
                    if (s_pd) m_strobe_done = 1;
                    else if (m_age - SETTLE == TMO) begin m_tmo = 1; m_strobe_done = 1; end
                end else if (!m_ext || !s_req) begin
                    m_in_seq = 0;
                end
            end
            if (!s_req) m_seen_low = 1;
            if (s_bp != m_prev_bp) m_armed = 1;
            m_prev_bp = s_bp;
        end
    endtask

    task automatic step();
        bit granted, strobe;
        logic [13:0] act, exp;
        @(negedge i_clk);
        model_update();
        granted = m_in_seq && (m_age >= SETTLE);
        strobe  = granted && !m_strobe_done;
        exp = {!m_in_seq, granted, strobe && !m_restore, strobe && m_restore,
               m_bp_hit, m_tmo, CW'(m_cnt)};
        act = {clk_en, tif.ti_gnt, tif.save, tif.restore, bp_hit, timeout_err, cyc_cnt};
        checkOutput("model", 32'(act), 32'(exp));
    endtask

    task automatic applyStimulus(vec_t v);
        tif.ti_req  = v.req;
        tif.ti_load = v.load;
        tif.pr_done = v.pd;
    endtask

    task automatic do_reset(int n);
        i_rst = 1'b1;
        repeat (n) step();
        i_rst = 1'b0;
    endtask

    initial begin
        int n;
        i_rst = 1'b1; breakpoint = CW'(CMAX); ap_start = 1'b0; ap_done = 1'b0;
        tif.ti_req = 1'b0; tif.ti_load = 1'b0; tif.pr_done = 1'b0;

        // Dump (entry 1 also shows pr_done ignored while settling).
        vecs[0]  = mk(1,0,0, 0,0,0,0); vecs[1]  = mk(1,0,1, 0,0,0,0);
        vecs[2]  = mk(1,0,0, 0,1,1,0); vecs[3]  = mk(1,0,0, 0,1,1,0);
        vecs[4]  = mk(1,0,1, 0,1,0,0); vecs[5]  = mk(1,0,0, 0,1,0,0);
        vecs[6]  = mk(0,0,0, 1,0,0,0); vecs[7]  = mk(0,0,0, 1,0,0,0);
        // Load.
        vecs[8]  = mk(1,1,0, 0,0,0,0); vecs[9]  = mk(1,1,0, 0,0,0,0);
        vecs[10] = mk(1,1,0, 0,1,0,1); vecs[11] = mk(1,1,0, 0,1,0,1);
        vecs[12] = mk(1,1,1, 0,1,0,0); vecs[13] = mk(1,1,0, 0,1,0,0);
        vecs[14] = mk(0,1,0, 1,0,0,0); vecs[15] = mk(0,1,0, 1,0,0,0);
        // One-cycle request aborts; pr_done ignored in RUN.
        vecs[16] = mk(1,0,0, 0,0,0,0); vecs[17] = mk(0,0,0, 1,0,0,0);
        vecs[18] = mk(0,0,1, 1,0,0,0);

        do_reset(10);
        checkOutput("rst_clk_en", 32'(clk_en), 32'd1);
        checkOutput("rst_outs", 32'({tif.ti_gnt, tif.save, tif.restore, bp_hit, timeout_err}), 32'd0);
        checkOutput("rst_cnt", 32'(cyc_cnt), 32'd0);

        ap_start = 1'b1;
        repeat (2) step();
        for (int i = 0; i < 19; i++) begin
            applyStimulus(vecs[i]);
            step();
            checkOutput($sformatf("vec%0d_clk_en", i), 32'(clk_en), 32'(vecs[i].ce));
            checkOutput($sformatf("vec%0d_gnt", i), 32'(tif.ti_gnt), 32'(vecs[i].gnt));
            checkOutput($sformatf("vec%0d_save", i), 32'(tif.save), 32'(vecs[i].sv));
            checkOutput($sformatf("vec%0d_restore", i), 32'(tif.restore), 32'(vecs[i].rs));
        end
        tif.pr_done = 1'b0;

        // Breakpoint at 100, no refire, re-arm at 150.
        breakpoint = 8'd100;
        do_reset(3);
        repeat (100) step();
        checkOutput("bp_pre_run", 32'(clk_en), 32'd1);
        checkOutput("bp_pre_cnt", 32'(cyc_cnt), 32'd100);
        step();
        checkOutput("bp_halt", 32'(clk_en), 32'd0);
        checkOutput("bp_halt_cnt", 32'(cyc_cnt), 32'd100);
        checkOutput("bp_hit", 32'(bp_hit), 32'd1);
        step(); step();
        checkOutput("bp_save", 32'({tif.ti_gnt, tif.save, tif.restore}), 32'b110);
        tif.pr_done = 1'b1; step(); tif.pr_done = 1'b0;
        checkOutput("bp_save_drop", 32'({tif.ti_gnt, tif.save}), 32'b10);
        step();
        checkOutput("bp_resume", 32'({clk_en, tif.ti_gnt}), 32'b10);
        n = 0;
        repeat (30) begin step(); if (clk_en !== 1'b1) n++; end
        checkOutput("bp_no_refire", 32'(n), 32'd0);
        checkOutput("bp_cnt_130", 32'(cyc_cnt), 32'd130);
        breakpoint = 8'd150;
        repeat (20) step();
        checkOutput("bp150_pre", 32'({clk_en, cyc_cnt}), 32'({1'b1, 8'd150}));
        step();
        checkOutput("bp150_halt", 32'(clk_en), 32'd0);
        step(); step();
        checkOutput("bp150_save", 32'(tif.save), 32'd1);
        tif.pr_done = 1'b1; step(); tif.pr_done = 1'b0; step();

        // Collision: external restore wins, breakpoint save follows.
        breakpoint = 8'd40;
        do_reset(3);
        repeat (40) step();
        tif.ti_req = 1'b1; tif.ti_load = 1'b1;
        step();
        checkOutput("col_halt", 32'({clk_en, bp_hit, cyc_cnt}), 32'({1'b0, 1'b0, 8'd40}));
        step(); step();
        checkOutput("col_restore", 32'({tif.save, tif.restore}), 32'b01);
        tif.pr_done = 1'b1; step(); tif.pr_done = 1'b0; tif.ti_req = 1'b0;
        step();
        checkOutput("col_back", 32'(clk_en), 32'd1);
        step();
        checkOutput("col_bp_fire", 32'({clk_en, bp_hit, cyc_cnt}), 32'({1'b0, 1'b1, 8'd40}));
        step(); step();
        checkOutput("col_bp_save", 32'({tif.save, tif.restore}), 32'b10);
        tif.pr_done = 1'b1; step(); tif.pr_done = 1'b0; step();

        // Timeout with no pr_done.
        breakpoint = CW'(CMAX); tif.ti_load = 1'b0;
        do_reset(3);
        step();
        tif.ti_req = 1'b1;
        repeat (3) step();
        checkOutput("tmo_save_on", 32'(tif.save), 32'd1);
        n = 1;
        for (int k = 0; k < 40; k++) begin
            step();
            if (tif.save !== 1'b1) break;
            n++;
        end
        checkOutput("tmo_strobe_len", 32'(n), 32'(TMO));
        checkOutput("tmo_err", 32'({timeout_err, tif.ti_gnt, clk_en}), 32'b110);
        repeat (3) step();
        checkOutput("tmo_hold", 32'(clk_en), 32'd0);
        tif.ti_req = 1'b0; step();
        checkOutput("tmo_resume", 32'({clk_en, tif.ti_gnt}), 32'b10);
        step();
        checkOutput("tmo_sticky", 32'(timeout_err), 32'd1);

        // Reset while in OP.
        tif.ti_req = 1'b1;
        repeat (3) step();
        checkOutput("rstop_pre", 32'(tif.save), 32'd1);
        i_rst = 1'b1; step();
        checkOutput("rstop_save", 32'(tif.save), 32'd0);
        checkOutput("rstop_clk_en", 32'(clk_en), 32'd1);
        checkOutput("rstop_tmo", 32'(timeout_err), 32'd0);
        i_rst = 1'b0; tif.ti_req = 1'b0; step();

        // Saturation with the breakpoint disabled.
        do_reset(2);
        repeat (300) step();
        checkOutput("sat_cnt", 32'(cyc_cnt), 32'(CMAX));
        checkOutput("sat_run", 32'(clk_en), 32'd1);

        // Random traffic against the model.
        for (int c = 0; c < 4000; c++) begin
            i_rst = ($urandom_range(0, 499) == 0);
            if ($urandom_range(0, 7) == 0) tif.ti_req = ~tif.ti_req;
            tif.ti_load = 1'($urandom_range(0, 1));
            tif.pr_done = ($urandom_range(0, 9) == 0);
            ap_start = ($urandom_range(0, 7) != 0);
            ap_done = ($urandom_range(0, 15) == 0);
            if ($urandom_range(0, 39) == 0) begin
                if ($urandom_range(0, 4) == 0) breakpoint = CW'(CMAX);
                else breakpoint = CW'(m_cnt + int'($urandom_range(0, 20)));
            end
            step();
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
